// File: rtl/apb_req_master.sv
// apb_req_master
//   Initiator side of the peripheral APB. Takes one valid/ready request from the
//   core interconnect and runs it as an APB3 transfer (SETUP -> ACCESS). It then
//   returns read data and error status on a valid/ready response port.
//   A per-transfer watchdog aborts an ACCESS phase that a hung slave never completes.
// Ports
//   clk_i, rst_i                        clock, synchronous active-high reset
//   req_valid_i/req_ready_o             request handshake
//   req_addr_i/req_we_i/req_wdata_i     request payload
//   rsp_valid_o/rsp_ready_i             response handshake
//   rsp_rdata_o/rsp_err_o               response payload
//   paddr_o/pwdata_o/pwrite_o           APB request side
//   psel_o/penable_o                    APB phase control
//   prdata_i/pready_i/pslverr_i         APB completion side
module apb_req_master #(
  parameter int APB_ADDR_WIDTH = 32,
  parameter int APB_DATA_WIDTH = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      req_valid_i,
  output logic                      req_ready_o,
  input  logic [APB_ADDR_WIDTH-1:0] req_addr_i,
  input  logic                      req_we_i,
  input  logic [APB_DATA_WIDTH-1:0] req_wdata_i,
  output logic                      rsp_valid_o,
  input  logic                      rsp_ready_i,
  output logic [APB_DATA_WIDTH-1:0] rsp_rdata_o,
  output logic                      rsp_err_o,
  output logic [APB_ADDR_WIDTH-1:0] paddr_o,
  output logic [APB_DATA_WIDTH-1:0] pwdata_o,
  output logic                      pwrite_o,
  output logic                      psel_o,
  output logic                      penable_o,
  input  logic [APB_DATA_WIDTH-1:0] prdata_i,
  input  logic                      pready_i,
  input  logic                      pslverr_i
);

  localparam bit WD_EN = (TIMEOUT_CYCLES != 0);
  localparam int WDW = WD_EN ? $clog2(TIMEOUT_CYCLES) + 1 : 1;
  localparam int WD_LAST_I = WD_EN ? TIMEOUT_CYCLES - 1 : 0;
  localparam logic [WDW-1:0] WD_LAST = WD_LAST_I[WDW-1:0];
  localparam logic [WDW-1:0] WD_MAX = '1;

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS, S_RESP} state_t;

  state_t                    r_state;
  logic [WDW-1:0]            r_wdog;
  logic                      r_req_ready;
  logic                      r_rsp_valid;
  logic [APB_DATA_WIDTH-1:0] r_rsp_rdata;
  logic                      r_rsp_err;
  logic [APB_ADDR_WIDTH-1:0] r_paddr;
  logic [APB_DATA_WIDTH-1:0] r_pwdata;
  logic                      r_pwrite;
  logic                      r_psel;
  logic                      r_penable;

  // Last ACCESS cycle the slave is allowed before the transfer is aborted.
  logic w_timeout;
  assign w_timeout = WD_EN && (r_wdog == WD_LAST);

  // Byte lanes of the address are dropped: APB transfers are word aligned.
  logic w_unused;
  assign w_unused = &{1'b0, req_addr_i[1:0]};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= S_IDLE;
      r_wdog      <= '0;
      r_req_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
      r_paddr     <= '0;
      r_pwdata    <= '0;
      r_pwrite    <= 1'b0;
      r_psel      <= 1'b0;
      r_penable   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid_i && r_req_ready) begin
            r_paddr     <= {req_addr_i[APB_ADDR_WIDTH-1:2], 2'b00};
            r_pwrite    <= req_we_i;
            r_pwdata    <= req_wdata_i;
            r_req_ready <= 1'b0;
            r_psel      <= 1'b1;
            r_wdog      <= '0;
            r_state     <= S_SETUP;
          end
        end
        S_SETUP: begin
          r_penable <= 1'b1;
          r_state   <= S_ACCESS;
        end
        S_ACCESS: begin
          // pready wins over a timeout landing on the same cycle.
          if (pready_i) begin
            r_psel      <= 1'b0;
            r_penable   <= 1'b0;
            r_rsp_rdata <= r_pwrite ? '0 : prdata_i;
            r_rsp_err   <= pslverr_i;
            r_rsp_valid <= 1'b1;
            r_state     <= S_RESP;
          end else if (w_timeout) begin
            r_psel      <= 1'b0;
            r_penable   <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b1;
            r_rsp_valid <= 1'b1;
            r_state     <= S_RESP;
          end else if (r_wdog != WD_MAX) begin
            r_wdog <= r_wdog + 1'b1;
          end
        end
        S_RESP: begin
          if (rsp_ready_i) begin
            r_rsp_valid <= 1'b0;
            r_req_ready <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign req_ready_o = r_req_ready;
  assign rsp_valid_o = r_rsp_valid;
  assign rsp_rdata_o = r_rsp_rdata;
  assign rsp_err_o   = r_rsp_err;
  assign paddr_o     = r_paddr;
  assign pwdata_o    = r_pwdata;
  assign pwrite_o    = r_pwrite;
  assign psel_o      = r_psel;
  assign penable_o   = r_penable;

endmodule

// File: tb/tb_apb_req_master.sv
module tb_apb_req_master;
  localparam int TO = 4;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic [31:0] req_addr_i = '0;
  logic        req_we_i = 1'b0;
  logic [31:0] req_wdata_i = '0;
  logic        rsp_valid_o;
  logic        rsp_ready_i = 1'b0;
  logic [31:0] rsp_rdata_o;
  logic        rsp_err_o;
  logic [31:0] paddr_o;
  logic [31:0] pwdata_o;
  logic        pwrite_o;
  logic        psel_o;
  logic        penable_o;
  logic [31:0] prdata_i = '0;
  logic        pready_i = 1'b0;
  logic        pslverr_i = 1'b0;

  apb_req_master #(.APB_ADDR_WIDTH(32), .APB_DATA_WIDTH(32), .TIMEOUT_CYCLES(TO)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_addr_i(req_addr_i),
    .req_we_i(req_we_i), .req_wdata_i(req_wdata_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_rdata_o(rsp_rdata_o),
    .rsp_err_o(rsp_err_o),
    .paddr_o(paddr_o), .pwdata_o(pwdata_o), .pwrite_o(pwrite_o), .psel_o(psel_o),
    .penable_o(penable_o), .prdata_i(prdata_i), .pready_i(pready_i), .pslverr_i(pslverr_i)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  // Slave behaviour for one transfer, chosen when the request is issued.
  typedef struct {
    logic [31:0] addr;
    bit          we;
    logic [31:0] wdata;
    int          w;      // wait states before pready; >= TO means the slave hangs
    bit          err;
    logic [31:0] rdata;
  } plan_t;

  typedef struct {
    logic [31:0] rdata;
    bit          err;
    int          acc;    // cycle of the request handshake
    int          lat;    // cycles from handshake to first rsp_valid
  } exp_t;

  plan_t plan_q[$];
  exp_t  exp_q[$];
  int    tests = 0;
  int    fails = 0;
  int    rdy_mode = 0;   // 0 random, 1 hold low, 2 hold high

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic flag(input string nm);
    tests++;
    fails++;
    $display("FAIL %s (cycle %0d)", nm, cyc);
  endtask

  // Reference: a hung slave is cut off after TO ACCESS cycles with an error;
  // otherwise the response mirrors the slave, with read data only for reads.
  function automatic exp_t model(input plan_t p, input int acc);
    exp_t e;
    e.acc = acc;
    if (p.w >= TO) begin
      e.err = 1'b1; e.rdata = '0; e.lat = 2 + TO;
    end else begin
      e.err = p.err; e.rdata = p.we ? 32'h0 : p.rdata; e.lat = 3 + p.w;
    end
    return e;
  endfunction

  // APB slave: inputs change on the falling edge for the next rising edge.
  plan_t cur;
  int    acc_cnt = 0;
  always @(negedge clk_i) begin
    pready_i  = 1'($urandom_range(0, 1));
    prdata_i  = $urandom;
    pslverr_i = 1'($urandom_range(0, 1));
    if (!rst_i && psel_o && !penable_o) begin
      pready_i = 1'b0;
      if (plan_q.size() == 0) flag("setup_without_request");
      else begin
        cur = plan_q.pop_front();
        acc_cnt = 0;
        chk("paddr", paddr_o, {cur.addr[31:2], 2'b00});
        chk("pwrite", 32'(pwrite_o), 32'(cur.we));
        chk("pwdata", pwdata_o, cur.wdata);
      end
    end else if (!rst_i && psel_o && penable_o) begin
      pready_i = 1'b0;
      if (acc_cnt == cur.w) begin
        pready_i = 1'b1; prdata_i = cur.rdata; pslverr_i = cur.err;
      end
      acc_cnt++;
    end
  end

  // Response monitor / scoreboard.
  bit seen = 0;
  always @(negedge clk_i) begin
    exp_t e;
    if (rst_i) begin
      seen = 0;
      rsp_ready_i = 1'b0;
    end else begin
      case (rdy_mode)
        1: rsp_ready_i = 1'b0;
        2: rsp_ready_i = 1'b1;
        default: rsp_ready_i = ($urandom_range(0, 9) < 7);
      endcase
      if (rsp_valid_o) begin
        if (exp_q.size() == 0) flag("unexpected_rsp");
        else begin
          e = exp_q[0];
          if (!seen) chk("rsp_latency", 32'(cyc - e.acc), 32'(e.lat));
          seen = 1;
          chk("rsp_rdata", rsp_rdata_o, e.rdata);
          chk("rsp_err", 32'(rsp_err_o), 32'(e.err));
          chk("psel_in_resp", 32'(psel_o), 32'h0);
          chk("req_ready_in_resp", 32'(req_ready_o), 32'h0);
          if (rsp_ready_i) begin
            void'(exp_q.pop_front());
            seen = 0;
          end
        end
      end
    end
  end

  task automatic issue(input logic [31:0] addr, input bit we, input logic [31:0] wd,
                       input int w, input bit err, input logic [31:0] rd);
    plan_t p;
    int n = 0;
    @(negedge clk_i);
    req_valid_i = 1'b1; req_addr_i = addr; req_we_i = we; req_wdata_i = wd;
    while (!req_ready_o && n < 2000) begin
      @(negedge clk_i);
      n++;
    end
    if (!req_ready_o) begin
      flag("req_accept_timeout");
      req_valid_i = 1'b0;
      return;
    end
    p.addr = addr; p.we = we; p.wdata = wd; p.w = w; p.err = err; p.rdata = rd;
    plan_q.push_back(p);
    exp_q.push_back(model(p, cyc));
    @(posedge clk_i);
    #1;
    req_valid_i = 1'b0;
    req_addr_i = $urandom; req_we_i = 1'($urandom_range(0, 1)); req_wdata_i = $urandom;
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((exp_q.size() != 0 || rsp_valid_o) && n < 500) begin
      @(negedge clk_i);
      n++;
    end
    if (n >= 500) flag("drain_timeout");
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int n, t, w;
    repeat (3) @(posedge clk_i);
    #1;
    chk("rst_req_ready", 32'(req_ready_o), 32'h1);
    chk("rst_rsp_valid", 32'(rsp_valid_o), 32'h0);
    chk("rst_rsp_rdata", rsp_rdata_o, 32'h0);
    chk("rst_rsp_err", 32'(rsp_err_o), 32'h0);
    chk("rst_psel", 32'(psel_o), 32'h0);
    chk("rst_penable", 32'(penable_o), 32'h0);
    chk("rst_pwrite", 32'(pwrite_o), 32'h0);
    chk("rst_paddr", paddr_o, 32'h0);
    chk("rst_pwdata", pwdata_o, 32'h0);
    @(negedge clk_i);
    rst_i = 1'b0;

    // Directed cases.
    issue(32'h1A10_0004, 1'b1, 32'hDEAD_BEEF, 0, 1'b0, 32'hFFFF_0000);
    wait_drain();
    issue(32'h1A10_1003, 1'b0, 32'h0, 2, 1'b0, 32'h1234_5678);
    wait_drain();
    issue(32'h1A10_2000, 1'b0, 32'h0, 1, 1'b1, 32'hCAFE_F00D);
    wait_drain();
    issue(32'h1A10_3000, 1'b0, 32'h0, 100, 1'b0, 32'h5555_AAAA);  // hung slave
    wait_drain();
    issue(32'h1A10_3004, 1'b0, 32'h0, TO - 1, 1'b0, 32'h0BAD_CAFE); // ready on last cycle
    wait_drain();
    issue(32'h1A10_3008, 1'b1, 32'h7777_8888, TO, 1'b0, 32'h0);     // one cycle too late
    wait_drain();

    // Response backpressure with a second request waiting.
    rdy_mode = 1;
    issue(32'h1A10_4000, 1'b0, 32'h0, 0, 1'b0, 32'h1111_2222);
    fork
      issue(32'h1A10_4004, 1'b1, 32'h3333_4444, 0, 1'b0, 32'h0);
    join_none
    n = 0;
    while (!rsp_valid_o && n < 50) begin @(negedge clk_i); n++; end
    repeat (10) begin
      @(negedge clk_i);
      chk("bp_req_ready", 32'(req_ready_o), 32'h0);
      chk("bp_rsp_valid", 32'(rsp_valid_o), 32'h1);
    end
    #1;
    t = cyc;
    rdy_mode = 2;
    n = 0;
    do begin @(negedge clk_i); n++; end while (!(psel_o && !penable_o) && n < 20);
    chk("bp_setup_cycle", 32'(cyc), 32'(t + 3));
    wait_drain();
    rdy_mode = 0;

    // Reset in the middle of an ACCESS phase.
    issue(32'h1A10_5000, 1'b0, 32'h0, 100, 1'b0, 32'h0);
    n = 0;
    while (!(psel_o && penable_o) && n < 20) begin @(negedge clk_i); n++; end
    @(negedge clk_i);
    rst_i = 1'b1;
    @(posedge clk_i);
    #1;
    chk("midrst_psel", 32'(psel_o), 32'h0);
    chk("midrst_penable", 32'(penable_o), 32'h0);
    chk("midrst_rsp_valid", 32'(rsp_valid_o), 32'h0);
    chk("midrst_req_ready", 32'(req_ready_o), 32'h1);
    exp_q.delete();
    plan_q.delete();
    @(negedge clk_i);
    rst_i = 1'b0;
    repeat (8) @(negedge clk_i);

    // Random traffic.
    for (int i = 0; i < 150; i++) begin
      w = ($urandom_range(0, 9) == 0) ? 50 : int'($urandom_range(0, TO + 1));
      issue($urandom, 1'($urandom_range(0, 1)), $urandom, w,
            ($urandom_range(0, 3) == 0), $urandom);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 4)) @(negedge clk_i);
    end
    wait_drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
